// File: rtl/test_pattern_pkg.sv
// Shared types, colour constants and helpers
// for the synthetic framebuffer RAM read port.
package test_pattern_pkg;

  typedef enum logic [2:0] {
    SOLID     = 3'd0,
    RGB_CYCLE = 3'd1,
    GRADIENT  = 3'd2,
    CHECKER   = 3'd3,
    SCROLL    = 3'd4
  } pattern_mode_t;

  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;

  localparam logic [15:0] RED       = 16'h8000;
  localparam logic [15:0] GREEN     = 16'h0600;
  localparam logic [15:0] BLUE      = 16'h0010;
  localparam logic [15:0] DIM_WHITE = 16'h2084;
  localparam logic [15:0] WHITE     = 16'hFFFF;

  // 4 == 1 (mod 3): fold base-4 digits, reducing as we go
  function automatic logic [1:0] mod3(input logic [63:0] v);
    logic [2:0] acc;
    acc = '0;
    for (int i = 31; i >= 0; i--) begin
      acc = acc + {1'b0, v[2*i +: 2]};
      if (acc >= 3'd3) acc = acc - 3'd3;
    end
    return acc[1:0];
  endfunction

endpackage

// File: rtl/test_pattern_ram_if.sv
// Read port plus pattern control seen by
// the framebuffer side of the test stub.
interface test_pattern_ram_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [15:0]           ram_rdata;
  logic [2:0]            mode;
  logic [1:0]            color_shift;
  logic [15:0]           solid_color;
  logic                  frame_tick;
  logic [15:0]           frame_count;

  modport master (
    output ram_raddr, mode, color_shift,
    output solid_color, frame_tick,
    input  ram_rdata, frame_count
  );

  modport slave (
    input  ram_raddr, mode, color_shift,
    input  solid_color, frame_tick,
    output ram_rdata, frame_count
  );
endinterface

// File: rtl/pixel_delay_line.sv
// Reset-to-zero register chain; depth 0
// degenerates to a plain wire.
module pixel_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = clk ^ rst_n;
    assign q = d;
  end else begin : g_regs
    logic [DEPTH-1:0][WIDTH-1:0] r;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r <= '0;
      end else begin
        r[0] <= d;
        for (int i = 1; i < DEPTH; i++)
          r[i] <= r[i-1];
      end
    end

    assign q = r[DEPTH-1];
  end
endmodule

// File: rtl/test_pattern_ram.sv
// Synthesises RGB565 pixels in place of the
// slice RAM, with frame-synchronous config.
module test_pattern_ram
  import test_pattern_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int PIXEL_BITS   = 10,
  parameter int CHECK_LOG2   = 3
) (
  input logic               clk_33,
  input logic               nrst,
  test_pattern_ram_if.slave bus
);
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $error("READ_LATENCY must be within 1..4");
  end

  pattern_mode_t         act_mode;
  logic [1:0]            act_shift;
  logic [15:0]           act_color;
  logic [15:0]           frame_cnt;
  logic [PIXEL_BITS-1:0] scroll_pos;
  logic [PIXEL_BITS-1:0] pix;
  logic [R_W-1:0]        grad_r;
  logic [2:0]            ksum;
  logic [1:0]            k;
  logic [15:0]           pix_d;
  logic [15:0]           pix_q;
  logic [15:0]           rdata;

  assign pix    = bus.ram_raddr[PIXEL_BITS-1:0];
  assign grad_r = pix[PIXEL_BITS-1 -: R_W];
  assign ksum   = {1'b0, mod3(64'(bus.ram_raddr))}
                + {1'b0, act_shift};
  assign k      = (ksum >= 3'd3) ? 2'(ksum - 3'd3)
                                 : ksum[1:0];

  always_comb begin
    pix_d = '0;
    case (act_mode)
      SOLID:     pix_d = act_color;
      RGB_CYCLE: begin
        if (act_shift == 2'd3) pix_d = DIM_WHITE;
        else if (k == 2'd0)    pix_d = RED;
        else if (k == 2'd1)    pix_d = GREEN;
        else                   pix_d = BLUE;
      end
      GRADIENT:  pix_d = {grad_r, {G_W{1'b0}}, ~grad_r};
      CHECKER:   pix_d = (pix[CHECK_LOG2] ^ frame_cnt[0])
                         ? WHITE : '0;
      SCROLL:    pix_d = (pix == scroll_pos) ? WHITE : '0;
      default:   pix_d = '0;
    endcase
  end

  // Config changes only at slice boundaries so a frame is never torn
  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      act_mode   <= SOLID;
      act_shift  <= '0;
      act_color  <= '0;
      frame_cnt  <= '0;
      scroll_pos <= '0;
      pix_q      <= '0;
    end else begin
      pix_q <= pix_d;
      if (bus.frame_tick) begin
        act_mode   <= pattern_mode_t'(bus.mode);
        act_shift  <= bus.color_shift;
        act_color  <= bus.solid_color;
        frame_cnt  <= frame_cnt + 16'd1;
        scroll_pos <= scroll_pos + PIXEL_BITS'(1);
      end
    end
  end

  pixel_delay_line #(
    .WIDTH (16),
    .DEPTH (READ_LATENCY - 1)
  ) u_dly (
    .clk   (clk_33),
    .rst_n (nrst),
    .d     (pix_q),
    .q     (rdata)
  );

  assign bus.ram_rdata   = rdata;
  assign bus.frame_count = frame_cnt;
endmodule

// File: tb/tb_test_pattern_ram.sv
// Scoreboard bench: latency-1 and latency-4
// instances driven in lockstep from one model.
module tb_test_pattern_ram;

  logic clk_33 = 1'b0;
  logic nrst;
  always #5 clk_33 = ~clk_33;

  test_pattern_ram_if #(.ADDR_WIDTH(32)) bus1 ();
  test_pattern_ram_if #(.ADDR_WIDTH(32)) bus4 ();

  test_pattern_ram #(
    .ADDR_WIDTH(32), .READ_LATENCY(1),
    .PIXEL_BITS(10), .CHECK_LOG2(3)
  ) dut1 (.clk_33(clk_33), .nrst(nrst), .bus(bus1));

  test_pattern_ram #(
    .ADDR_WIDTH(32), .READ_LATENCY(4),
    .PIXEL_BITS(10), .CHECK_LOG2(3)
  ) dut4 (.clk_33(clk_33), .nrst(nrst), .bus(bus4));

  typedef struct {
    int          due;
    logic [15:0] exp;
    logic [31:0] addr;
  } sb_t;

  sb_t q1[$];
  sb_t q4[$];

  int cyc;
  int vectors;
  int miscompares;

  logic [2:0]  in_mode;
  logic [1:0]  in_shift;
  logic [15:0] in_color;

  logic [2:0]  m_mode;
  logic [1:0]  m_shift;
  logic [15:0] m_color;
  logic [15:0] m_fc;
  logic [9:0]  m_scroll;

  function automatic logic [15:0] model(input logic [31:0] a);
    logic [9:0] p;
    logic [4:0] r;
    int kk;
    p = a[9:0];
    r = p[9:5];
    case (m_mode)
      3'd0: return m_color;
      3'd1: begin
        if (m_shift == 2'd3) return 16'b00100_000100_00100;
        kk = (int'(a % 32'd3) + int'(m_shift)) % 3;
        if (kk == 0) return 16'b10000_000000_00000;
        if (kk == 1) return 16'b00000_110000_00000;
        return 16'b00000_000000_10000;
      end
      3'd2: return {r, 6'd0, ~r};
      3'd3: return (p[3] ^ m_fc[0]) ? 16'hFFFF : 16'h0000;
      3'd4: return (p == m_scroll) ? 16'hFFFF : 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 3'd0; m_shift = 2'd0; m_color = 16'd0;
    m_fc = 16'd0; m_scroll = 10'd0;
    q1.delete();
    q4.delete();
  endtask

  task automatic step(input logic [31:0] a, input logic tick, input bit push);
    sb_t e;
    @(negedge clk_33);
    cyc++;
    while (q1.size() > 0 && q1[0].due <= cyc) begin
      e = q1.pop_front();
      vectors++;
      if (bus1.ram_rdata !== e.exp) begin
        miscompares++;
        $display("FAIL rdata_lat1 addr=%h got=%h exp=%h",
                 e.addr, bus1.ram_rdata, e.exp);
      end
    end
    while (q4.size() > 0 && q4[0].due <= cyc) begin
      e = q4.pop_front();
      vectors++;
      if (bus4.ram_rdata !== e.exp) begin
        miscompares++;
        $display("FAIL rdata_lat4 addr=%h got=%h exp=%h",
                 e.addr, bus4.ram_rdata, e.exp);
      end
    end
    vectors++;
    if (bus1.frame_count !== m_fc || bus4.frame_count !== m_fc) begin
      miscompares++;
      $display("FAIL frame_count got=%h/%h exp=%h",
               bus1.frame_count, bus4.frame_count, m_fc);
    end
    bus1.ram_raddr = a;         bus4.ram_raddr = a;
    bus1.frame_tick = tick;     bus4.frame_tick = tick;
    bus1.mode = in_mode;        bus4.mode = in_mode;
    bus1.color_shift = in_shift; bus4.color_shift = in_shift;
    bus1.solid_color = in_color; bus4.solid_color = in_color;
    if (push) begin
      e.addr = a;
      e.exp  = model(a);
      e.due  = cyc + 1;
      q1.push_back(e);
      e.due  = cyc + 4;
      q4.push_back(e);
    end
    if (tick) begin
      m_mode = in_mode; m_shift = in_shift; m_color = in_color;
      m_fc = m_fc + 16'd1;
      m_scroll = m_scroll + 10'd1;
    end
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk_33);
    cyc++;
    nrst = 1'b0;
    #1;
    vectors++;
    if (bus1.ram_rdata !== 16'h0 || bus4.ram_rdata !== 16'h0) begin
      miscompares++;
      $display("FAIL %s_rdata got=%h/%h exp=0000",
               tag, bus1.ram_rdata, bus4.ram_rdata);
    end
    vectors++;
    if (bus1.frame_count !== 16'h0 || bus4.frame_count !== 16'h0) begin
      miscompares++;
      $display("FAIL %s_frame_count got=%h/%h exp=0000",
               tag, bus1.frame_count, bus4.frame_count);
    end
    model_reset();
    @(negedge clk_33);
    cyc++;
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset("reset");
    for (int i = 0; i < 6; i++) step(32'(i), 1'b0, 1'b1);
  endtask

  task automatic test_rgb_cycle();
    in_mode = 3'd1; in_shift = 2'd0;
    step(32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(32'(i), 1'b0, 1'b1);
    in_shift = 2'd2;
    step(32'd9, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(32'(i), 1'b0, 1'b1);
    in_shift = 2'd3;
    step(32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(32'(i), 1'b0, 1'b1);
  endtask

  task automatic test_mod3_edge();
    in_mode = 3'd1; in_shift = 2'd0;
    step(32'd0, 1'b1, 1'b1);
    step(32'hFFFF_FFFF, 1'b0, 1'b1);
    step(32'hFFFF_FFFE, 1'b0, 1'b1);
    step(32'hFFFF_FFFD, 1'b0, 1'b1);
    step(32'h8000_0000, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) step($urandom, 1'b0, 1'b1);
  endtask

  task automatic test_mode_change();
    in_mode = 3'd0; in_color = 16'h1234;
    for (int i = 0; i < 4; i++) step(32'(i), 1'b0, 1'b1);
    step(32'd4, 1'b1, 1'b1);
    for (int i = 5; i < 9; i++) step(32'(i), 1'b0, 1'b1);
    in_mode = 3'd6;
    step(32'd9, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(32'(i), 1'b0, 1'b1);
  endtask

  task automatic test_gradient();
    in_mode = 3'd2;
    step(32'd0, 1'b1, 1'b1);
    step(32'd0, 1'b0, 1'b1);
    step(32'd31, 1'b0, 1'b1);
    step(32'd32, 1'b0, 1'b1);
    step(32'd1023, 1'b0, 1'b1);
    step(32'd1524, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step($urandom, 1'b0, 1'b1);
  endtask

  task automatic test_checker();
    in_mode = 3'd3;
    step(32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step(32'(i), 1'b0, 1'b1);
    step(32'd16, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step(32'(i), 1'b0, 1'b1);
  endtask

  task automatic test_scroll();
    apply_reset("scroll_reset");
    in_mode = 3'd4;
    for (int i = 0; i < 1023; i++) step(32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 1024; i++) step(32'(i), 1'b0, 1'b1);
    step(32'd0, 1'b1, 1'b1);
    step(32'd0, 1'b0, 1'b1);
    vectors++;
    if (bus4.frame_count !== 16'd1024) begin
      miscompares++;
      $display("FAIL scroll_frame_count got=%0d exp=1024",
               bus4.frame_count);
    end
    for (int i = 1; i < 4; i++) step(32'(i), 1'b0, 1'b1);
    for (int i = 1020; i < 1024; i++) step(32'(i), 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back_reset();
    in_mode = 3'd1; in_shift = 2'd0;
    step(32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(32'(i), 1'b0, 1'b1);
    apply_reset("midstream_reset");
    for (int i = 0; i < 8; i++) step(32'(i), 1'b0, 1'b1);
  endtask

  initial begin
    cyc = 0; vectors = 0; miscompares = 0;
    in_mode = 3'd0; in_shift = 2'd0; in_color = 16'd0;
    model_reset();
    nrst = 1'b0;
    bus1.ram_raddr = '0;  bus4.ram_raddr = '0;
    bus1.frame_tick = 0;  bus4.frame_tick = 0;
    bus1.mode = '0;       bus4.mode = '0;
    bus1.color_shift = 0; bus4.color_shift = 0;
    bus1.solid_color = 0; bus4.solid_color = 0;
    test_reset();
    test_rgb_cycle();
    test_mod3_edge();
    test_mode_change();
    test_gradient();
    test_checker();
    test_scroll();
    test_back_to_back_reset();
    for (int i = 0; i < 5; i++) step(32'd0, 1'b0, 1'b0);
    vectors++;
    if (q1.size() != 0 || q4.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d/%0d exp=0",
               q1.size(), q4.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/test_pattern_ram.md
# test_pattern_ram

Parametrised, multi-mode replacement for the framebuffer's RAM read port on bench boards: answers `ram_raddr` with a synthesised RGB565 pixel after a configurable read latency. Sits between `framebuffer` and the (absent) slice RAM in board test tops, so driver, mux and LED wiring can be validated without SDRAM or the SoC stream. Generalises the fixed R/G/B-cycling stub to several patterns, frame-synchronous mode switching and an animated scroll mode.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of `ram_raddr`
- `READ_LATENCY`, 1, cycles from address to data; legal 1..4
- `PIXEL_BITS`, 10, pixel index = `ram_raddr[PIXEL_BITS-1:0]`; slice length 2^PIXEL_BITS
- `CHECK_LOG2`, 3, checkerboard tile size 2^CHECK_LOG2 pixels

Ports (one clock; reset is asynchronous and active-low):
- `clk_33`  in  1  pixel clock, all logic on rising edge
- `nrst`  in  1  asynchronous active-low reset
- `ram_raddr`  in  ADDR_WIDTH  read address from `framebuffer`
- `ram_rdata`  out  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}
- `mode`  in  3  requested pattern (package enum)
- `color_shift`  in  2  RGB_CYCLE phase; 3 = dim white
- `solid_color`  in  16  colour for SOLID
- `frame_tick`  in  1  one-cycle pulse per slice/turn (`position_sync` rate)
- `frame_count`  out  16  number of `frame_tick` pulses seen, wraps

## Operation
- Active config (`act_mode`, `act_shift`, `act_color`) is loaded from inputs only on a cycle with `frame_tick`=1; mid-slice input changes never affect output.
- Modes:
  - SOLID (0): `act_color`.
  - RGB_CYCLE (1): k = (`ram_raddr` mod 3 + `act_shift`) mod 3; k=0 RED 16'b10000_000000_00000, k=1 GREEN 16'b00000_110000_00000, k=2 BLUE 16'b00000_000000_10000; `act_shift`=3 -> DIM_WHITE 16'b00100_000100_00100 for all addresses.
  - GRADIENT (2): R = pixel index top 5 bits, G = 0, B = ~R.
  - CHECKER (3): white 16'hFFFF if pixel_index[CHECK_LOG2] xor `frame_count`[0], else 0.
  - SCROLL (4): 16'hFFFF when pixel index == `scroll_pos`, else 0.
  - 5..7 reserved: output 0.
- `scroll_pos` (PIXEL_BITS): +1 on each `frame_tick`, natural wrap 2^PIXEL_BITS-1 -> 0.
- mod 3 over full ADDR_WIDTH computed without a divider (bit-pair folding function); must be exact for all addresses incl. all-ones.
- `frame_count` +1 per `frame_tick`, wraps 16'hFFFF -> 0.

## Timing
- Reset: `ram_rdata`=0, all pipeline stages=0, `frame_count`=0, `scroll_pos`=0, `act_mode`=SOLID, `act_shift`=0, `act_color`=0.
- Latency: address presented in cycle n -> data on `ram_rdata` at end of cycle n+READ_LATENCY-1 edge (visible cycle n+READ_LATENCY); stage 1 registers pattern result, stages 2..READ_LATENCY pure delay. New address every cycle, throughput 1/cycle.
- `frame_tick` in cycle n: active config, `scroll_pos`, `frame_count` update at that edge; addresses issued from cycle n+1 use new config. Address issued in cycle n itself uses old config.
- `frame_tick` held high: updates every cycle (treated as repeated ticks).
- Reset mid-stream: pipeline flushed to 0 immediately (async); first valid data READ_LATENCY cycles after release.
- Out-of-range READ_LATENCY: elaboration error.

## Structure
- Package `test_pattern_pkg`: `pattern_mode_t` enum (SOLID..SCROLL), RED/GREEN/BLUE/DIM_WHITE/WHITE constants, RGB565 field widths, `mod3` function.
- Sub-module `pixel_delay_line` (#WIDTH, #DEPTH): reset-to-zero register chain implementing stages 2..READ_LATENCY; DEPTH=0 is a wire.

## Test plan
- RGB_CYCLE, shift 0, latency 1, addr 0,1,2,3 consecutive -> rdata RED,GREEN,BLUE,RED one cycle later each; shift 2 -> BLUE,RED,GREEN; shift 3 -> DIM_WHITE constant.
- mod3 edge: addr 32'hFFFF_FFFF, shift 0 -> RED (2^32-1 mod 3 = 0); addr 32'hFFFF_FFFE -> BLUE.
- Mode change mid-slice: set mode=SOLID, solid_color=16'h1234 without tick -> output unchanged; pulse frame_tick -> next address returns 16'h1234.
- SCROLL, PIXEL_BITS=10: 1023 ticks then sweep 0..1023 -> only pixel 1023 white; one more tick -> only pixel 0 white, frame_count=1024.
- READ_LATENCY=4: addr stream 0..7 in RGB_CYCLE -> first data cycle 4, sequence intact; assert nrst low mid-stream -> rdata 0 same cycle, frame_count 0, act_mode SOLID.
- CHECKER, CHECK_LOG2=3: pixels 0..7 black, 8..15 white; after one tick inverted.
